// File: rtl/pc_sequencer_if.sv
// Bus between the program-counter sequencer and its control/ALU/instruction-memory
// neighbours. The table buses are packed: entry i sits at [i*PC_BITS +: PC_BITS].
interface pc_sequencer_if #(
    parameter int PC_BITS     = 10,
    parameter int TARGET_BITS = 8,
    parameter int NUM_PROGS   = 4,
    parameter int SEL_BITS    = 2,
    parameter int CNT_BITS    = 16
);
    // req/ack: req is a level. A low-to-high req in IDLE starts one run, and ack
    // rises when the run finishes. ack stays high until req drops, so a held req
    // never starts a second run.
    logic                           req;
    logic [SEL_BITS-1:0]            prog_sel;
    logic [NUM_PROGS*PC_BITS-1:0]   start_addrs;
    logic [NUM_PROGS*PC_BITS-1:0]   done_addrs;
    logic                           next_ins;
    logic                           jump_flag;
    logic                           jump_rel;
    logic [TARGET_BITS-1:0]         target;
    logic [PC_BITS-1:0]             pc_out;
    logic                           running;
    logic                           ack;
    logic [CNT_BITS-1:0]            cycle_count;
    logic                           fault;

    modport master (
        output req, prog_sel, start_addrs, done_addrs, next_ins, jump_flag, jump_rel, target,
        input  pc_out, running, ack, cycle_count, fault
    );

    modport slave (
        input  req, prog_sel, start_addrs, done_addrs, next_ins, jump_flag, jump_rel, target,
        output pc_out, running, ack, cycle_count, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: runs one of NUM_PROGS start/done address ranges per
// request, with stall, absolute/relative jumps, a run cycle counter and a sticky fault.
module pc_sequencer #(
    parameter int PC_BITS     = 10,
    parameter int TARGET_BITS = 8,
    parameter int NUM_PROGS   = 4,
    parameter int SEL_BITS    = 2,
    parameter int CNT_BITS    = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    pc_sequencer_if.slave        bus,
    output logic [1:0]           dbgState
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seqState;

    localparam logic [SEL_BITS:0] NUM_PROGS_W = (SEL_BITS + 1)'(NUM_PROGS);

    seqState               stateReg, stateNext;
    logic [PC_BITS-1:0]    pcReg, pcNext;
    logic                  ackReg, ackNext;
    logic                  runReg, runNext;
    logic [CNT_BITS-1:0]   cntReg, cntNext;
    logic                  faultReg, faultNext;
    logic [SEL_BITS-1:0]   selReg, selNext;

    logic                  selValid;
    logic [PC_BITS-1:0]    startAddr;
    logic [PC_BITS-1:0]    doneAddr;
    logic [PC_BITS-1:0]    absTarget;
    logic [PC_BITS-1:0]    relOffset;

    assign selValid  = {1'b0, bus.prog_sel} < NUM_PROGS_W;
    // The start address comes from the incoming index; it is only used when selValid.
    assign startAddr = bus.start_addrs[bus.prog_sel*PC_BITS +: PC_BITS];
    assign doneAddr  = bus.done_addrs[selReg*PC_BITS +: PC_BITS];

    if (TARGET_BITS >= PC_BITS) begin : gNarrowPc
        assign absTarget = bus.target[PC_BITS-1:0];
        assign relOffset = bus.target[PC_BITS-1:0];
    end else begin : gWidePc
        assign absTarget = {{(PC_BITS-TARGET_BITS){1'b0}}, bus.target};
        assign relOffset = {{(PC_BITS-TARGET_BITS){bus.target[TARGET_BITS-1]}}, bus.target};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stateReg <= IDLE;
            pcReg    <= '0;
            ackReg   <= 1'b0;
            runReg   <= 1'b0;
            cntReg   <= '0;
            faultReg <= 1'b0;
            selReg   <= '0;
        end else begin
            stateReg <= stateNext;
            pcReg    <= pcNext;
            ackReg   <= ackNext;
            runReg   <= runNext;
            cntReg   <= cntNext;
            faultReg <= faultNext;
            selReg   <= selNext;
        end
    end

    always_comb begin
        stateNext = stateReg;
        pcNext    = pcReg;
        ackNext   = ackReg;
        runNext   = runReg;
        cntNext   = cntReg;
        faultNext = faultReg;
        selNext   = selReg;
        case (stateReg)
            IDLE: begin
                if (bus.req) begin
                    if (selValid) begin
                        selNext   = bus.prog_sel;
                        pcNext    = startAddr;
                        cntNext   = '0;
                        faultNext = 1'b0;
                        runNext   = 1'b1;
                        stateNext = RUN;
                    end else begin
                        faultNext = 1'b1;
                    end
                end
            end
            RUN: begin
                if (cntReg != '1) begin
                    cntNext = cntReg + 1'b1;
                end
                // Reaching the done address wins over any jump requested that cycle.
                if (bus.next_ins) begin
                    if (pcReg == doneAddr) begin
                        stateNext = DONE;
                        ackNext   = 1'b1;
                        runNext   = 1'b0;
                    end else if (bus.jump_flag) begin
                        pcNext = bus.jump_rel ? pcReg + relOffset : absTarget;
                    end else begin
                        pcNext = pcReg + 1'b1;
                        if (pcReg == '1) begin
                            faultNext = 1'b1;
                        end
                    end
                end
            end
            DONE: begin
                if (!bus.req) begin
                    ackNext   = 1'b0;
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign bus.pc_out      = pcReg;
    assign bus.running     = runReg;
    assign bus.ack         = ackReg;
    assign bus.cycle_count = cntReg;
    assign bus.fault       = faultReg;
    assign dbgState        = stateReg;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: reset, sequential runs, jumps, stall, wrap fault,
// invalid program index, done-over-jump priority and a single-cycle program.
module tb_pc_sequencer;
    localparam int PC_BITS     = 10;
    localparam int TARGET_BITS = 8;
    localparam int NUM_PROGS   = 4;
    localparam int SEL_BITS    = 3;
    localparam int CNT_BITS    = 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic       clock;
    logic       reset;
    logic [1:0] dbg_state;
    int         total_cnt;
    int         bad_cnt;
    logic [PC_BITS-1:0] exp_q[$];

    pc_sequencer_if #(
        .PC_BITS(PC_BITS), .TARGET_BITS(TARGET_BITS), .NUM_PROGS(NUM_PROGS),
        .SEL_BITS(SEL_BITS), .CNT_BITS(CNT_BITS)
    ) bus ();

    pc_sequencer #(
        .PC_BITS(PC_BITS), .TARGET_BITS(TARGET_BITS), .NUM_PROGS(NUM_PROGS),
        .SEL_BITS(SEL_BITS), .CNT_BITS(CNT_BITS)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus(bus),
        .dbgState(dbg_state)
    );

    // clock / reset
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard step: advance one cycle and compare pc_out with the next expected address.
    task automatic tick_pc(input string tag);
        logic [PC_BITS-1:0] exp_pc;
        tick();
        if (exp_q.size() == 0) begin
            check_val({tag, "_queue_empty"}, 32'd0, 32'd1);
        end else begin
            exp_pc = exp_q.pop_front();
            check_val(tag, 32'(bus.pc_out), 32'(exp_pc));
        end
    endtask

    task automatic wait_ack(input int budget);
        int n = 0;
        while (!bus.ack && n < budget) begin
            tick();
            n++;
        end
        check_val("ack_within_budget", {31'b0, bus.ack}, 32'd1);
    endtask

    task automatic set_entry(input int idx, input logic [PC_BITS-1:0] st, input logic [PC_BITS-1:0] dn);
        bus.start_addrs[idx*PC_BITS +: PC_BITS] = st;
        bus.done_addrs[idx*PC_BITS +: PC_BITS]  = dn;
    endtask

    initial begin
        total_cnt     = 0;
        bad_cnt       = 0;
        reset         = 1'b1;
        bus.req       = 1'b0;
        bus.prog_sel  = '0;
        bus.next_ins  = 1'b1;
        bus.jump_flag = 1'b0;
        bus.jump_rel  = 1'b0;
        bus.target    = '0;
        bus.start_addrs = '0;
        bus.done_addrs  = '0;
        set_entry(0, 10'h000, 10'h00A);
        set_entry(1, 10'h010, 10'h013);
        set_entry(2, 10'h020, 10'h050);
        set_entry(3, 10'h3FE, 10'h002);
        tick();
        tick();
        reset = 1'b0;

        // reset state
        check_val("rst_pc", 32'(bus.pc_out), 32'h0);
        check_val("rst_running", 32'(bus.running), 32'd0);
        check_val("rst_ack", 32'(bus.ack), 32'd0);
        check_val("rst_cnt", 32'(bus.cycle_count), 32'd0);
        check_val("rst_fault", 32'(bus.fault), 32'd0);
        check_val("rst_state", 32'(dbg_state), 32'(ST_IDLE));

        // reset in the middle of a run at pc 0x005
        bus.req = 1'b1; bus.prog_sel = 3'd0;
        tick();
        bus.req = 1'b0;
        repeat (5) tick();
        check_val("mid_run_pc", 32'(bus.pc_out), 32'h005);
        check_val("mid_run_running", 32'(bus.running), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("rst_run_pc", 32'(bus.pc_out), 32'h0);
        check_val("rst_run_running", 32'(bus.running), 32'd0);
        check_val("rst_run_ack", 32'(bus.ack), 32'd0);
        check_val("rst_run_cnt", 32'(bus.cycle_count), 32'd0);
        check_val("rst_run_state", 32'(dbg_state), 32'(ST_IDLE));

        // program 1: 0x010..0x013, req held high through DONE
        exp_q.push_back(10'h010);
        exp_q.push_back(10'h011);
        exp_q.push_back(10'h012);
        exp_q.push_back(10'h013);
        bus.req = 1'b1; bus.prog_sel = 3'd1;
        tick_pc("p1_pc0");
        check_val("p1_running", 32'(bus.running), 32'd1);
        check_val("p1_cnt_start", 32'(bus.cycle_count), 32'd0);
        tick_pc("p1_pc1");
        tick_pc("p1_pc2");
        tick_pc("p1_pc3");
        check_val("p1_ack_early", 32'(bus.ack), 32'd0);
        tick();
        check_val("p1_ack", 32'(bus.ack), 32'd1);
        check_val("p1_running_done", 32'(bus.running), 32'd0);
        check_val("p1_cnt", 32'(bus.cycle_count), 32'd4);
        check_val("p1_pc_hold", 32'(bus.pc_out), 32'h013);
        tick();
        check_val("p1_ack_hold", 32'(bus.ack), 32'd1);
        check_val("p1_no_restart", 32'(dbg_state), 32'(ST_DONE));
        bus.req = 1'b0;
        tick();
        check_val("p1_ack_clear", 32'(bus.ack), 32'd0);
        check_val("p1_idle", 32'(dbg_state), 32'(ST_IDLE));
        check_val("p1_cnt_hold", 32'(bus.cycle_count), 32'd4);

        // out-of-range program index
        bus.req = 1'b1; bus.prog_sel = 3'd5;
        tick();
        check_val("bad_sel_fault", 32'(bus.fault), 32'd1);
        check_val("bad_sel_state", 32'(dbg_state), 32'(ST_IDLE));
        check_val("bad_sel_pc", 32'(bus.pc_out), 32'h013);
        bus.prog_sel = 3'd0;
        tick();
        check_val("good_sel_fault", 32'(bus.fault), 32'd0);
        check_val("good_sel_running", 32'(bus.running), 32'd1);
        check_val("good_sel_pc", 32'(bus.pc_out), 32'h000);
        bus.req = 1'b0;
        wait_ack(20);
        check_val("p0_done_pc", 32'(bus.pc_out), 32'h00A);
        check_val("p0_cnt", 32'(bus.cycle_count), 32'd11);
        tick();

        // jumps and stall on program 2 (0x020..0x050)
        bus.req = 1'b1; bus.prog_sel = 3'd2;
        tick();
        bus.req = 1'b0;
        check_val("j_start_pc", 32'(bus.pc_out), 32'h020);
        bus.jump_flag = 1'b1; bus.jump_rel = 1'b0; bus.target = 8'h45;
        tick();
        check_val("j_abs_pc", 32'(bus.pc_out), 32'h045);
        bus.target = 8'h20;
        tick();
        check_val("j_abs_back_pc", 32'(bus.pc_out), 32'h020);
        bus.jump_rel = 1'b1; bus.target = 8'hFE;
        tick();
        check_val("j_rel_neg_pc", 32'(bus.pc_out), 32'h01E);
        check_val("j_cnt_before_stall", 32'(bus.cycle_count), 32'd3);
        bus.jump_flag = 1'b0; bus.next_ins = 1'b0;
        repeat (3) tick();
        check_val("stall_pc", 32'(bus.pc_out), 32'h01E);
        check_val("stall_cnt", 32'(bus.cycle_count), 32'd6);
        bus.next_ins = 1'b1;
        tick();
        check_val("resume_pc", 32'(bus.pc_out), 32'h01F);
        bus.jump_flag = 1'b1; bus.jump_rel = 1'b1; bus.target = 8'h05;
        tick();
        check_val("j_rel_pos_pc", 32'(bus.pc_out), 32'h024);
        bus.jump_rel = 1'b0; bus.target = 8'h50;
        tick();
        check_val("j_to_done_pc", 32'(bus.pc_out), 32'h050);
        bus.jump_flag = 1'b0;
        tick();
        check_val("j_ack", 32'(bus.ack), 32'd1);
        check_val("j_cnt", 32'(bus.cycle_count), 32'd10);
        check_val("j_fault", 32'(bus.fault), 32'd0);
        tick();
        check_val("j_idle", 32'(dbg_state), 32'(ST_IDLE));

        // wrap of pc from 0x3FF to 0x000 on program 3
        exp_q.push_back(10'h3FE);
        exp_q.push_back(10'h3FF);
        exp_q.push_back(10'h000);
        exp_q.push_back(10'h001);
        exp_q.push_back(10'h002);
        bus.req = 1'b1; bus.prog_sel = 3'd3;
        tick_pc("w_pc0");
        bus.req = 1'b0;
        tick_pc("w_pc1");
        check_val("w_fault_pre", 32'(bus.fault), 32'd0);
        tick_pc("w_pc2");
        check_val("w_fault", 32'(bus.fault), 32'd1);
        check_val("w_running", 32'(bus.running), 32'd1);
        tick_pc("w_pc3");
        tick_pc("w_pc4");
        tick();
        check_val("w_ack", 32'(bus.ack), 32'd1);
        check_val("w_pc_done", 32'(bus.pc_out), 32'h002);
        check_val("w_fault_sticky", 32'(bus.fault), 32'd1);
        check_val("w_cnt", 32'(bus.cycle_count), 32'd5);
        tick();

        // jump on the done cycle: done wins, req held through DONE
        bus.req = 1'b1; bus.prog_sel = 3'd1;
        tick();
        check_val("pr_fault_cleared", 32'(bus.fault), 32'd0);
        repeat (3) tick();
        check_val("pr_at_done_pc", 32'(bus.pc_out), 32'h013);
        bus.jump_flag = 1'b1; bus.jump_rel = 1'b0; bus.target = 8'h77;
        tick();
        check_val("pr_state", 32'(dbg_state), 32'(ST_DONE));
        check_val("pr_pc", 32'(bus.pc_out), 32'h013);
        check_val("pr_ack", 32'(bus.ack), 32'd1);
        repeat (3) tick();
        check_val("pr_held_state", 32'(dbg_state), 32'(ST_DONE));
        check_val("pr_held_pc", 32'(bus.pc_out), 32'h013);
        check_val("pr_held_running", 32'(bus.running), 32'd0);
        bus.jump_flag = 1'b0; bus.req = 1'b0;
        tick();
        check_val("pr_idle", 32'(dbg_state), 32'(ST_IDLE));

        // single-cycle program: start == done
        set_entry(2, 10'h020, 10'h020);
        bus.req = 1'b1; bus.prog_sel = 3'd2;
        tick();
        bus.req = 1'b0;
        check_val("sc_pc", 32'(bus.pc_out), 32'h020);
        tick();
        check_val("sc_ack", 32'(bus.ack), 32'd1);
        check_val("sc_cnt", 32'(bus.cycle_count), 32'd1);
        check_val("sc_pc_hold", 32'(bus.pc_out), 32'h020);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Parametrised successor to the single-program counter in the CPU top level.
- Holds a table of NUM_PROGS start/done address pairs and runs the program chosen by prog_sel on a req/ack handshake.
- Supports stall, absolute and PC-relative jumps, a per-run cycle counter and a sticky fault flag.
- Drives the instruction-memory address; it is driven by control (next_ins) and by the ALU (jump_flag, target).

Parameters:
PC_BITS, 10, width of program counter and of table addresses
TARGET_BITS, 8, width of the jump target from the ALU
NUM_PROGS, 4, number of start/done address pairs
SEL_BITS, 2, width of prog_sel; must satisfy 2^SEL_BITS >= NUM_PROGS
CNT_BITS, 16, width of cycle_count

Ports:
clock  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req  input  1  start request (level)
prog_sel  input  SEL_BITS  program index, sampled on accepted req
start_addrs  input  NUM_PROGS*PC_BITS  flattened start addresses; entry i at bits [i*PC_BITS +: PC_BITS]
done_addrs  input  NUM_PROGS*PC_BITS  flattened done addresses, same packing
next_ins  input  1  advance enable from control; 0 = stall
jump_flag  input  1  take jump this advance
jump_rel  input  1  1 = relative jump, 0 = absolute
target  input  TARGET_BITS  jump target or offset
pc_out  output  PC_BITS  current instruction address
running  output  1  high while in RUN
ack  output  1  program complete
cycle_count  output  CNT_BITS  RUN cycles of the current or last run
fault  output  1  sticky error flag

Behaviour:
- Reset (synchronous, wins over all inputs, valid in any state):
  - state = IDLE, pc_out = 0, ack = 0, running = 0, cycle_count = 0, fault = 0.
  - The latched program index is cleared to 0.
- FSM states are IDLE, RUN and DONE; all outputs are registered.
- IDLE:
  - If req = 1 and prog_sel < NUM_PROGS:
    - latch sel = prog_sel;
    - pc_out <= start_addrs[sel];
    - cycle_count <= 0, fault <= 0;
    - go to RUN (running = 1 from the next cycle).
  - If req = 1 and prog_sel >= NUM_PROGS: fault <= 1, stay in IDLE, pc_out unchanged.
  - If req = 0: hold all outputs.
- RUN, every cycle:
  - cycle_count += 1, saturating at all-ones.
  - If next_ins = 0: pc_out holds (stall).
  - If next_ins = 1 and pc_out == done_addrs[sel]: go to DONE, pc_out holds, ack <= 1, running <= 0. This check has priority over any jump.
  - Otherwise, if next_ins = 1 and jump_flag = 1:
    - jump_rel = 0: pc_out <= zero-extended target (truncated if TARGET_BITS > PC_BITS);
    - jump_rel = 1: pc_out <= pc_out + sign-extended target, modulo 2^PC_BITS.
  - Otherwise, if next_ins = 1: pc_out <= pc_out + 1.
  - Wrap of pc_out+1 from all-ones to 0 sets fault <= 1. The run continues.
  - Relative-jump wrap does not set fault.
  - req is ignored during RUN; prog_sel changes have no effect.
- DONE:
  - ack stays 1 and pc_out and cycle_count hold.
  - When req = 0: ack <= 0 and go to IDLE.
  - A new run needs req to go low and then high again; a held req never restarts.
- Table inputs are read combinationally from the latched sel. They must be stable during a run.
- Single-cycle program (start == done, next_ins = 1 on the first RUN cycle): reach DONE after 1 RUN cycle, with cycle_count = 1.

Test Plan:
- Reset during RUN at pc = 0x005 -> next cycle pc_out = 0, running = 0, ack = 0, cycle_count = 0, state IDLE.
- Program 1 (start = 0x010, done = 0x013), next_ins = 1 constantly, no jumps, req pulsed -> pc_out goes 0x010, 0x011, 0x012, 0x013; ack rises the cycle after 0x013 is seen; cycle_count = 4; ack holds until req = 0, then clears.
- At pc = 0x020, jump_flag = 1:
  - jump_rel = 0, target = 0x45 -> pc_out = 0x045;
  - jump_rel = 1, target = 0xFE (-2) -> pc_out = 0x01E;
  - with next_ins = 0 for 3 cycles -> pc_out holds, cycle_count still +3.
- start = 0x3FE, done = 0x002, PC_BITS = 10 -> sequence 0x3FE, 0x3FF, 0x000 with fault = 1 asserted and remaining set; completes at 0x002 with ack = 1.
- prog_sel = 5 with NUM_PROGS = 4 (SEL_BITS = 3), req = 1 -> fault = 1, stays IDLE, pc_out unchanged. A following valid req with prog_sel = 0 clears fault and starts.
- jump_flag = 1 on the cycle pc_out == done -> DONE taken, pc_out holds at the done address. A req held high through DONE does not restart the run.
